mem_responder: RTL and testbench
================================

Name: mem_responder

Overview:
- Memory-side responder for the single-requester memory handshake used by ringBuffer and memoryArbitration clients (mem_enable / mem_readWrite / mem_address / mem_DataWrite → mem_DataOut / mem_done).
- Owns an internal 32-bit word RAM, services one request at a time with programmable latency, and pulses done on completion.
- Lets a client (ringBuffer, or an arbiter output port) run against a real backing store without the arbiter.

Parameters:
- ADDR_W, 15, address width in words.
- DEPTH, 32768, implemented words; addresses >= DEPTH are out of range. Must satisfy DEPTH <= 2^ADDR_W.
- LATENCY, 2, cycles spent in ACCESS, minimum 1.

Ports:
- clk  in  1  single clock; all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- mem_enable  in  1  request, level; held high by the client until it sees mem_done.
- mem_readWrite  in  1  1 = read, 0 = write.
- mem_address  in  ADDR_W  word address.
- mem_DataWrite  in  32  write data.
- mem_DataOut  out  32  read data; holds the last successful read.
- mem_done  out  1  one-cycle completion pulse.
- mem_busy  out  1  high in every state except IDLE.
- mem_err  out  1  valid with mem_done; 1 = address out of range.

Behaviour:
- Reset (async, any state): state=IDLE; mem_DataOut=0, mem_done=0, mem_busy=0, mem_err=0; LATENCY counter=0. RAM contents are not cleared. Reset mid-access aborts the access with no RAM write.
- States: IDLE, ACCESS, DONE, RELEASE.
- IDLE: at an edge with mem_enable=1, latch readWrite, address and DataWrite; cnt=LATENCY-1; go to ACCESS. Inputs are ignored after latching.
- ACCESS, cnt>0: cnt--.
- ACCESS, cnt==0:
  - In-range write: RAM[addr]=data; mem_DataOut unchanged.
  - In-range read: mem_DataOut=RAM[addr].
  - Out of range: no write; a read sets mem_DataOut=0.
  - Then mem_done=1, mem_err=out_of_range, go to DONE.
- Result: mem_done is high during the cycle after edge k+LATENCY, where k is the latch edge.
- DONE (1 cycle): mem_done=0, mem_err=0. If mem_enable=1, go to RELEASE, else IDLE.
- RELEASE: wait for mem_enable=0, then IDLE. A held-high enable never retriggers.
- Minimum request spacing: a new request needs enable low for at least one sampled edge after done.
- Enable dropped during ACCESS: the access still completes and done still pulses. DONE then goes to IDLE.
- Read after write to the same address returns the new data.
- Back-to-back requests: mem_readWrite, mem_address and mem_DataWrite are sampled only in IDLE.
- Out-of-range reads and writes still complete the handshake; there is no hang.
- RAM: synchronous single-port, inferable as BRAM; one access per request.

Test Plan:
- Reset, then write addr 0x0003 = 0x0000000a with LATENCY=2: mem_done pulses exactly 1 cycle, 2 edges after the latch edge; mem_busy high from the latch edge until RELEASE/IDLE; mem_err=0; mem_DataOut stays 0.
- Write 0x0004 = 0x0000000b, write 0x0002 = 0x00000002, then read 0x0003, 0x0004, 0x0002: mem_DataOut = 0x0000000a, 0x0000000b, 0x00000002, each valid with its mem_done pulse.
- Hold mem_enable high for 10 cycles after one read: exactly one mem_done pulse and state parks in RELEASE. Drop enable and re-raise it with a new address: a second access is serviced.
- DEPTH=16, read 0x0020 and write 0x0020 = 0xdeadbeef: mem_done with mem_err=1 for both, mem_DataOut=0 after the read, and reading 0x0000 shows no aliasing write.
- Assert rst during ACCESS of write 0x0005 = 0x12345678: outputs go to 0 immediately, no mem_done, and a later read of 0x0005 does not return 0x12345678 (prewrite 0x5 = 0x1 first; expect 0x1).
- ringBuffer connected directly (enable/readWrite/address/DataWrite ↔ DataOut/done), RAM preloaded with words 0x2..0x4 = 0x2, 0xa, 0xb: dataToInterpreter presents 0x0000000a then 0x0000000b on successive exec_done pulses.

Source files
------------

// File: rtl/mem_responder.sv
// mem_responder: single-requester memory handshake responder with internal word RAM and programmable latency.
module mem_responder #(
  parameter int ADDR_W = 15,
  parameter int DEPTH = 32768,
  parameter int LATENCY = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_enable,
  input  logic              mem_readWrite,
  input  logic [ADDR_W-1:0] mem_address,
  input  logic [31:0]       mem_DataWrite,
  output logic [31:0]       mem_DataOut,
  output logic              mem_done,
  output logic              mem_busy,
  output logic              mem_err
);
  localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  localparam int CW = LATENCY > 1 ? $clog2(LATENCY) : 1;
  typedef enum logic [1:0] {IDLE, ACCESS, DONE, RELEASE} state_t;
  state_t state, state_n;
  logic rw_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0] data_q;
  logic [CW-1:0] cnt;
  logic [31:0] mem [DEPTH];
  logic fire, in_range;
  assign in_range = {1'b0, addr_q} < (ADDR_W+1)'(DEPTH);
  assign fire = state == ACCESS && cnt == '0;
  assign mem_busy = state != IDLE;
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_n;
  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:    if (mem_enable) state_n = ACCESS;
      ACCESS:  if (cnt == '0) state_n = DONE;
      DONE:    state_n = mem_enable ? RELEASE : IDLE;
      RELEASE: if (!mem_enable) state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      rw_q <= 1'b0;
      addr_q <= '0;
      data_q <= '0;
      cnt <= '0;
      mem_DataOut <= '0;
      mem_done <= 1'b0;
      mem_err <= 1'b0;
    end else begin
      mem_done <= fire;
      mem_err <= fire && !in_range;
      if (state == IDLE && mem_enable) begin
        rw_q <= mem_readWrite;
        addr_q <= mem_address;
        data_q <= mem_DataWrite;
        cnt <= CW'(LATENCY - 1);
      end
      if (state == ACCESS && cnt != '0) cnt <= cnt - 1'b1;
      if (fire && rw_q) mem_DataOut <= in_range ? mem[addr_q[AW-1:0]] : '0;
    end
  // Out-of-range addresses never reach the array, so no aliasing onto low words.
  always_ff @(posedge clk)
    if (fire && !rw_q && in_range) mem[addr_q[AW-1:0]] <= data_q;
endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder: scoreboard-driven bench for mem_responder (DEPTH=16, LATENCY=2).
module tb_mem_responder;
  logic clk = 0, rst = 1, en = 0, rw = 0;
  logic [14:0] addr = '0;
  logic [31:0] wd = '0;
  logic [31:0] mem_DataOut;
  logic mem_done, mem_busy, mem_err;
  int passed = 0, total = 0;
  typedef struct packed {logic [31:0] data; logic err;} exp_t;
  exp_t exp_q[$];
  logic [31:0] mdl [16];
  logic [31:0] last_dout = '0;

  mem_responder #(.ADDR_W(15), .DEPTH(16), .LATENCY(2)) dut (
    .clk(clk), .rst(rst), .mem_enable(en), .mem_readWrite(rw), .mem_address(addr),
    .mem_DataWrite(wd), .mem_DataOut(mem_DataOut), .mem_done(mem_done),
    .mem_busy(mem_busy), .mem_err(mem_err)
  );

  always #5 clk = ~clk;

  function automatic exp_t expect_of(input logic r, input logic [14:0] a, input logic [31:0] d);
    exp_t e;
    e.err = a >= 16;
    if (r) last_dout = e.err ? 32'h0 : mdl[a[3:0]];
    else if (!e.err) mdl[a[3:0]] = d;
    e.data = last_dout;
    return e;
  endfunction

  task automatic transact(input logic r, input logic [14:0] a, input logic [31:0] d, input bit keep, output int lat);
    @(negedge clk);
    en = 1; rw = r; addr = a; wd = d; lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!mem_done && lat < 20);
    if (!keep) en = 0;
  endtask

  task automatic test_reset;
    repeat (2) @(negedge clk);
    total += 4;
    if (mem_DataOut !== 32'h0) $display("FAIL reset_dout got %h exp 0", mem_DataOut); else passed++;
    if (mem_done !== 1'b0) $display("FAIL reset_done got %b exp 0", mem_done); else passed++;
    if (mem_busy !== 1'b0) $display("FAIL reset_busy got %b exp 0", mem_busy); else passed++;
    if (mem_err !== 1'b0) $display("FAIL reset_err got %b exp 0", mem_err); else passed++;
    rst = 0;
  endtask

  task automatic test_write;
    exp_t e;
    int lat;
    bit busy_ok;
    exp_q.push_back(expect_of(1'b0, 15'h3, 32'h0000000a));
    @(negedge clk);
    en = 1; rw = 0; addr = 15'h3; wd = 32'h0000000a; lat = 0; busy_ok = 1;
    do begin
      @(negedge clk);
      lat++;
      wd = 32'hffffffff;
      if (!mem_busy) busy_ok = 0;
    end while (!mem_done && lat < 20);
    e = exp_q.pop_front();
    total += 4;
    if (lat !== 3) $display("FAIL write_latency got %0d exp 3", lat); else passed++;
    if (!busy_ok) $display("FAIL write_busy got 0 exp 1"); else passed++;
    if (mem_DataOut !== e.data) $display("FAIL write_dout got %h exp %h", mem_DataOut, e.data); else passed++;
    if (mem_err !== e.err) $display("FAIL write_err got %b exp %b", mem_err, e.err); else passed++;
    en = 0;
    @(negedge clk);
    total += 2;
    if (mem_done !== 1'b0) $display("FAIL write_done_width got %b exp 0", mem_done); else passed++;
    if (mem_busy !== 1'b0) $display("FAIL write_busy_idle got %b exp 0", mem_busy); else passed++;
  endtask

  task automatic test_readback;
    logic [14:0] as [5] = '{15'h4, 15'h2, 15'h3, 15'h4, 15'h2};
    logic [31:0] ds [5] = '{32'hb, 32'h2, 32'h0, 32'h0, 32'h0};
    logic rs [5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    exp_t e;
    int lat;
    for (int i = 0; i < 5; i++) begin
      exp_q.push_back(expect_of(rs[i], as[i], ds[i]));
      transact(rs[i], as[i], ds[i], 0, lat);
      e = exp_q.pop_front();
      total += 3;
      if (lat !== 3) $display("FAIL rb_latency[%0d] got %0d exp 3", i, lat); else passed++;
      if (mem_DataOut !== e.data) $display("FAIL rb_dout[%0d] got %h exp %h", i, mem_DataOut, e.data); else passed++;
      if (mem_err !== e.err) $display("FAIL rb_err[%0d] got %b exp %b", i, mem_err, e.err); else passed++;
    end
  endtask

  task automatic test_hold;
    exp_t e;
    int lat, extra;
    exp_q.push_back(expect_of(1'b1, 15'h4, 32'h0));
    transact(1'b1, 15'h4, 32'h0, 1, lat);
    e = exp_q.pop_front();
    total += 2;
    if (lat !== 3) $display("FAIL hold_latency got %0d exp 3", lat); else passed++;
    if (mem_DataOut !== e.data) $display("FAIL hold_dout got %h exp %h", mem_DataOut, e.data); else passed++;
    extra = 0;
    repeat (10) begin
      @(negedge clk);
      if (mem_done) extra++;
    end
    total += 2;
    if (extra !== 0) $display("FAIL hold_extra_done got %0d exp 0", extra); else passed++;
    if (mem_busy !== 1'b1) $display("FAIL hold_parked got %b exp 1", mem_busy); else passed++;
    en = 0;
    @(negedge clk);
    total++;
    if (mem_busy !== 1'b0) $display("FAIL hold_release got %b exp 0", mem_busy); else passed++;
    exp_q.push_back(expect_of(1'b1, 15'h2, 32'h0));
    transact(1'b1, 15'h2, 32'h0, 0, lat);
    e = exp_q.pop_front();
    total += 2;
    if (lat !== 3) $display("FAIL hold_retrigger_latency got %0d exp 3", lat); else passed++;
    if (mem_DataOut !== e.data) $display("FAIL hold_retrigger_dout got %h exp %h", mem_DataOut, e.data); else passed++;
  endtask

  task automatic test_out_of_range;
    logic [14:0] as [6] = '{15'h0, 15'hf, 15'h20, 15'h20, 15'h10, 15'h0};
    logic [31:0] ds [6] = '{32'h11, 32'h0f0f, 32'h0, 32'hdeadbeef, 32'h0, 32'h0};
    logic rs [6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    exp_t e;
    int lat;
    for (int i = 0; i < 6; i++) begin
      exp_q.push_back(expect_of(rs[i], as[i], ds[i]));
      transact(rs[i], as[i], ds[i], 0, lat);
      e = exp_q.pop_front();
      total += 3;
      if (lat !== 3) $display("FAIL oor_latency[%0d] got %0d exp 3", i, lat); else passed++;
      if (mem_DataOut !== e.data) $display("FAIL oor_dout[%0d] got %h exp %h", i, mem_DataOut, e.data); else passed++;
      if (mem_err !== e.err) $display("FAIL oor_err[%0d] got %b exp %b", i, mem_err, e.err); else passed++;
    end
    exp_q.push_back(expect_of(1'b1, 15'hf, 32'h0));
    transact(1'b1, 15'hf, 32'h0, 0, lat);
    e = exp_q.pop_front();
    total += 2;
    if (mem_DataOut !== e.data) $display("FAIL oor_top_word got %h exp %h", mem_DataOut, e.data); else passed++;
    if (mem_err !== e.err) $display("FAIL oor_top_err got %b exp %b", mem_err, e.err); else passed++;
  endtask

  task automatic test_reset_mid;
    exp_t e;
    int lat, seen;
    exp_q.push_back(expect_of(1'b0, 15'h5, 32'h1));
    transact(1'b0, 15'h5, 32'h1, 0, lat);
    void'(exp_q.pop_front());
    exp_q.push_back(expect_of(1'b1, 15'h4, 32'h0));
    transact(1'b1, 15'h4, 32'h0, 0, lat);
    e = exp_q.pop_front();
    total++;
    if (mem_DataOut !== e.data) $display("FAIL rstmid_pre_dout got %h exp %h", mem_DataOut, e.data); else passed++;
    @(negedge clk);
    en = 1; rw = 0; addr = 15'h5; wd = 32'h12345678;
    @(negedge clk);
    rst = 1;
    #1;
    last_dout = '0;
    total += 3;
    if (mem_DataOut !== 32'h0) $display("FAIL rstmid_dout got %h exp 0", mem_DataOut); else passed++;
    if (mem_busy !== 1'b0) $display("FAIL rstmid_busy got %b exp 0", mem_busy); else passed++;
    if (mem_done !== 1'b0) $display("FAIL rstmid_done got %b exp 0", mem_done); else passed++;
    en = 0;
    @(negedge clk);
    rst = 0;
    seen = 0;
    repeat (5) begin
      @(negedge clk);
      if (mem_done) seen++;
    end
    total++;
    if (seen !== 0) $display("FAIL rstmid_no_done got %0d exp 0", seen); else passed++;
    exp_q.push_back(expect_of(1'b1, 15'h5, 32'h0));
    transact(1'b1, 15'h5, 32'h0, 0, lat);
    e = exp_q.pop_front();
    total += 2;
    if (lat !== 3) $display("FAIL rstmid_read_latency got %0d exp 3", lat); else passed++;
    if (mem_DataOut !== e.data) $display("FAIL rstmid_read_dout got %h exp %h", mem_DataOut, e.data); else passed++;
  endtask

  task automatic test_client_stream;
    logic [14:0] as [5] = '{15'h2, 15'h3, 15'h4, 15'h3, 15'h4};
    logic [31:0] ds [5] = '{32'h2, 32'ha, 32'hb, 32'h0, 32'h0};
    logic rs [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    exp_t e;
    int lat;
    for (int i = 0; i < 5; i++) begin
      exp_q.push_back(expect_of(rs[i], as[i], ds[i]));
      transact(rs[i], as[i], ds[i], 0, lat);
      e = exp_q.pop_front();
      if (rs[i]) begin
        total += 2;
        if (lat !== 3) $display("FAIL stream_latency[%0d] got %0d exp 3", i, lat); else passed++;
        if (mem_DataOut !== e.data) $display("FAIL stream_dout[%0d] got %h exp %h", i, mem_DataOut, e.data); else passed++;
      end
    end
  endtask

  initial begin
    test_reset;
    test_write;
    test_readback;
    test_hold;
    test_out_of_range;
    test_reset_mid;
    test_client_stream;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
